// File: rtl/operand_fwd_stage.sv
// Forwarding stage ahead of the three-input operand mux. It tracks the two newest in-flight
// ALU results on b/c and registers the mux select for each issued operand.
module operand_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [CNT_W-1:0]  fwd_count
);

    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_S1 = 2'b01,
        SEL_S2 = 2'b10
    } sel_e;

    // Stage2 keeps only its data: its address and valid bit retire into the
    // register file before anything could match against them.
    logic              v1;
    logic [REG_AW-1:0] rd1;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    sel_e              sel_q;
    sel_e              sel_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              rs_nonzero;
    logic              hit_wb;
    logic              hit_s1;

    assign rs_nonzero = (issue_rs != '0);
    assign hit_wb     = wb_valid && wb_we && (wb_rd == issue_rs) && rs_nonzero;
    assign hit_s1     = v1 && (rd1 == issue_rs) && rs_nonzero;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        sel_d = SEL_RF;
        cnt_d = cnt_q;
        if (issue_valid) begin
            if (hit_wb)
                sel_d = SEL_S1;
            else if (hit_s1)
                sel_d = SEL_S2;
        end
        if ((sel_d != SEL_RF) && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so the stage1->stage2 shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too, so b and c read as zero straight out of reset.
            v1    <= 1'b0;
            rd1   <= '0;
            d1    <= '0;
            d2    <= '0;
            sel_q <= SEL_RF;
            cnt_q <= '0;
        end else begin
            d2 <= d1;
            if (wb_valid) begin
                v1  <= wb_we && (wb_rd != '0);
                rd1 <= wb_rd;
                d1  <= wb_data;
            end else begin
                v1 <= 1'b0;
            end
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign sel       = sel_q;
    assign b         = d1;
    assign c         = d2;
    assign fwd_count = cnt_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Scoreboard bench for operand_fwd_stage: directed scenarios plus random traffic,
// expected outputs come from a register-level forwarding model.
module tb_operand_fwd_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs;
    logic              wb_valid;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        sel;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [CNT_W-1:0]  fwd_count;

    operand_fwd_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs(issue_rs),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel(sel), .b(b), .c(c), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        sel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: the last value written on wb (what b shows), the value b showed before
    // that (c), the register written in the previous cycle and whether it could be forwarded.
    logic [DATA_W-1:0] m_b, m_c;
    int                m_cnt;
    bit                m_prev_ok;
    int                m_prev_rd;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit r, input bit iv, input int rs,
                       input bit wv, input bit we, input int rd, input logic [DATA_W-1:0] data);
        exp_t e;
        rst = r; issue_valid = iv; issue_rs = REG_AW'(rs);
        wb_valid = wv; wb_we = we; wb_rd = REG_AW'(rd); wb_data = data;
        if (r) begin
            m_b = '0; m_c = '0; m_cnt = 0; m_prev_ok = 0; m_prev_rd = 0;
            e.sel = 2'b00;
        end else begin
            e.sel = 2'b00;
            if (iv && rs != 0) begin
                if (wv && we && rd == rs)
                    e.sel = 2'b01;
                else if (m_prev_ok && m_prev_rd == rs)
                    e.sel = 2'b10;
            end
            m_c = m_b;
            if (wv) m_b = data;
            m_prev_ok = wv && we && (rd != 0);
            m_prev_rd = rd;
            if (e.sel != 2'b00 && m_cnt < CNT_MAX) m_cnt++;
        end
        e.b = m_b; e.c = m_c; e.cnt = CNT_W'(m_cnt);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel", DATA_W'(sel), DATA_W'(e.sel));
                check("b", b, e.b);
                check("c", c, e.c);
                check("fwd_count", DATA_W'(fwd_count), DATA_W'(e.cnt));
            end
        end
    end

    initial begin
        m_b = '0; m_c = '0; m_cnt = 0; m_prev_ok = 0; m_prev_rd = 0;
        rst = 1'b1; issue_valid = 0; issue_rs = '0;
        wb_valid = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
        @(posedge clk); #1;

        // Reset held with wb and issue active
        cyc(1, 1, 3, 1, 1, 3, 32'hDEAD_BEEF);
        cyc(1, 1, 3, 1, 1, 3, 32'hDEAD_BEEF);
        idle(1);

        // Same-cycle forward
        cyc(0, 1, 3, 1, 1, 3, 32'h0000_0002);
        idle(3);
        // Older forward from stage1
        cyc(0, 0, 0, 1, 1, 4, 32'h0000_0003);
        cyc(0, 1, 4, 1, 1, 5, 32'h0000_0001);
        idle(3);
        // Same-cycle result beats older result for the same register
        cyc(0, 0, 0, 1, 1, 7, 32'hAAAA_0000);
        cyc(0, 1, 7, 1, 1, 7, 32'h0000_BBBB);
        idle(3);
        // Register 0 never forwarded
        cyc(0, 1, 0, 1, 1, 0, 32'h1234_5678);
        cyc(0, 1, 0, 0, 0, 0, '0);
        idle(2);
        // Non-writing result cannot match, same cycle or next
        cyc(0, 1, 8, 1, 0, 8, 32'h5555_5555);
        cyc(0, 1, 8, 0, 0, 0, '0);
        idle(2);
        // Retired entries are not forwarded
        cyc(0, 0, 0, 1, 1, 9, 32'h9999_0009);
        idle(1);
        cyc(0, 1, 9, 0, 0, 0, '0);
        cyc(0, 1, 9, 0, 0, 0, '0);
        idle(2);

        // Saturation: 17 forwarding issues in a row
        for (int k = 0; k < 17; k++) cyc(0, 1, 6, 1, 1, 6, DATA_W'(k + 100));
        // Mid-sequence reset clears the counter and in-flight entries
        cyc(1, 1, 6, 1, 1, 6, 32'hFFFF_0000);
        cyc(0, 1, 6, 0, 0, 0, '0);
        idle(2);

        // Random traffic on a small register range to provoke frequent hits
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 5),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 5),
                $urandom());
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", DATA_W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
